// File: rtl/alu_banked_seq.sv
// Banked register-file ALU. Most ops complete in one cycle. Shifts by a
// non-zero amount run one bit per cycle in SHIFT. A combinational peek
// port exposes any register.
module alu_banked_seq #(
  parameter int WIDTH  = 16,
  parameter int NREGS  = 4,
  parameter int NBANKS = 4,
  localparam int RW = $clog2(NREGS),
  localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op,
  input  logic [RW-1:0]    rd,
  input  logic [RW-1:0]    rs,
  input  logic [BW-1:0]    bank,
  input  logic [WIDTH-1:0] arg,
  input  logic [WIDTH-1:0] from_ram,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] muldiv,
  input  logic             ext_we,
  input  logic [WIDTH-1:0] ext_data,
  input  logic [BW-1:0]    dbg_bank,
  input  logic [RW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data,
  output logic             done,
  output logic             overflow,
  output logic             read_req
);

  localparam logic [3:0] OP_NOP = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4,  OP_RES = 4'd5,  OP_READ = 4'd6, OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8,  OP_XOR = 4'd9,  OP_NOT = 4'd10, OP_DEC = 4'd11;
  localparam logic [3:0] OP_INC = 4'd12, OP_SET = 4'd13, OP_IN  = 4'd14, OP_MOV = 4'd15;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [SW-1:0]    CNT_1 = SW'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] regs [NBANKS][NREGS];

  // Shift context, frozen at accept so later input changes cannot disturb it
  logic [WIDTH-1:0] sh_val;
  logic [SW-1:0]    sh_cnt;
  logic             sh_left, sh_ovf;
  logic [BW-1:0]    sh_bank;
  logic [RW-1:0]    sh_rd;

  logic [WIDTH-1:0] op_a, op_b, res, sh_next;
  logic [SW-1:0]    amt;
  logic [WIDTH:0]   wide;
  logic             res_we, res_ovf, start_shift, accept, sh_last, sh_ovf_next;

  assign op_ready = !rst && (state_q == IDLE) && !ext_we;
  assign accept   = op_valid && op_ready;
  assign read_req = accept && (op == OP_READ);
  assign dbg_data = regs[dbg_bank][dbg_sel];

  assign op_a = regs[bank][rd];
  assign op_b = (arg != '0) ? arg : regs[bank][rs];
  assign amt  = op_b[SW-1:0];

  assign sh_next     = sh_left ? {sh_val[WIDTH-2:0], 1'b0} : {1'b0, sh_val[WIDTH-1:1]};
  assign sh_ovf_next = sh_ovf | (sh_left & sh_val[WIDTH-1]);
  assign sh_last     = (sh_cnt == CNT_1);

  // Single-cycle result. A shift with a non-zero amount only requests SHIFT.
  always_comb begin
    res         = '0;
    res_ovf     = 1'b0;
    res_we      = 1'b1;
    start_shift = 1'b0;
    wide        = '0;
    case (op)
      OP_ADD:  begin wide = {1'b0, op_a} + {1'b0, op_b}; res = wide[WIDTH-1:0]; res_ovf = wide[WIDTH]; end
      OP_SUB:  begin res = op_a - op_b; res_ovf = (op_a < op_b); end
      OP_AND:  res = op_a & op_b;
      OP_OR:   res = op_a | op_b;
      OP_XOR:  res = op_a ^ op_b;
      OP_NOT:  res = ~op_a;
      OP_DEC:  begin res = op_a - ONE; res_ovf = (op_a == '0); end
      OP_INC:  begin wide = {1'b0, op_a} + {1'b0, ONE}; res = wide[WIDTH-1:0]; res_ovf = wide[WIDTH]; end
      OP_SET:  res = arg;
      OP_MOV:  res = regs[bank][rs];
      OP_IN:   res = in_data;
      OP_RES:  res = muldiv;
      OP_READ: res = from_ram;
      OP_SHL, OP_SHR: begin
        if (amt == '0) res = op_a;
        else begin res_we = 1'b0; start_shift = 1'b1; end
      end
      default: res_we = 1'b0;  // NOP
    endcase
  end

  // Next-state: enter SHIFT on a multi-cycle shift, leave on the final bit
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && start_shift) state_d = SHIFT;
      SHIFT:   if (sh_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Register file, flags and shift datapath. The shift write sits after the
  // external write, so it wins when both target the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NBANKS; b++)
        for (int r = 0; r < NREGS; r++)
          regs[b][r] <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      sh_cnt   <= '0;
      sh_val   <= '0;
      sh_ovf   <= 1'b0;
      sh_left  <= 1'b0;
      sh_bank  <= '0;
      sh_rd    <= '0;
    end else begin
      done <= 1'b0;
      if (ext_we) regs[bank][rd] <= ext_data;
      if (accept) begin
        if (res_we) regs[bank][rd] <= res;
        if (start_shift) begin
          sh_val  <= op_a;
          sh_cnt  <= amt;
          sh_left <= (op == OP_SHL);
          sh_ovf  <= 1'b0;
          sh_bank <= bank;
          sh_rd   <= rd;
        end else begin
          done <= 1'b1;
          if (op != OP_NOP) overflow <= res_ovf;
        end
      end
      if (state_q == SHIFT) begin
        sh_val <= sh_next;
        sh_ovf <= sh_ovf_next;
        sh_cnt <= sh_cnt - CNT_1;
        if (sh_last) begin
          regs[sh_bank][sh_rd] <= sh_next;
          overflow             <= sh_ovf_next;
          done                 <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_banked_seq.sv
// Bench for alu_banked_seq. It runs a directed vector table, hand-written
// corner sequences and random ops scored against an arithmetic model.
module tb_alu_banked_seq;

  logic        clk, rst, op_valid, op_ready, ext_we, done, overflow, read_req;
  logic [3:0]  op;
  logic [1:0]  rd, rs, bank, dbg_bank, dbg_sel;
  logic [15:0] arg, from_ram, in_data, muldiv, ext_data, dbg_data;

  alu_banked_seq #(.WIDTH(16), .NREGS(4), .NBANKS(4)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .rd(rd), .rs(rs), .bank(bank), .arg(arg), .from_ram(from_ram),
    .in_data(in_data), .muldiv(muldiv), .ext_we(ext_we), .ext_data(ext_data),
    .dbg_bank(dbg_bank), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .done(done), .overflow(overflow), .read_req(read_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [15:0] m [4][4];
  logic        m_ovf;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  rd, rs, bank;
    logic [15:0] arg, ram, inp, md, res;
    logic        ovf;
    int          lat;
  } vec_t;
  vec_t tv [26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic peek(input logic [1:0] b, input logic [1:0] s, output logic [15:0] v);
    dbg_bank = b; dbg_sel = s; #1; v = dbg_data;
  endtask

  task automatic scan_all(input string name);
    logic [15:0] v;
    for (int b = 0; b < 4; b++)
      for (int s = 0; s < 4; s++) begin
        peek(2'(b), 2'(s), v);
        chk(name, v, m[b][s]);
      end
  endtask

  function automatic vec_t mk(input logic [3:0] o, input logic [1:0] d, input logic [1:0] s,
                              input logic [1:0] b, input logic [15:0] a, input logic [15:0] ram,
                              input logic [15:0] inp, input logic [15:0] md, input logic [15:0] r,
                              input logic ov, input int lat);
    vec_t v;
    v.op = o; v.rd = d; v.rs = s; v.bank = b; v.arg = a; v.ram = ram; v.inp = inp;
    v.md = md; v.res = r; v.ovf = ov; v.lat = lat;
    return v;
  endfunction

  // Reference: plain integer arithmetic on the model register file
  task automatic model_op(input logic [3:0] o, input logic [1:0] d, input logic [1:0] s,
                          input logic [1:0] b, input logic [15:0] a, input logic [15:0] ram,
                          input logic [15:0] inp, input logic [15:0] md,
                          output logic [15:0] r, output logic ov, output int lat);
    int A, B, amt;
    longint full;
    A = int'(m[b][d]);
    B = (a != 0) ? int'(a) : int'(m[b][s]);
    amt = B % 16;
    r = m[b][d]; ov = 1'b0; lat = 1;
    case (o)
      4'd0:  ov = m_ovf;
      4'd1:  begin full = longint'(A) + B; r = 16'(full); ov = (full > 65535); end
      4'd2:  begin r = 16'(A - B); ov = (A < B); end
      4'd3:  r = 16'(A & B);
      4'd4:  r = 16'(A | B);
      4'd5:  r = md;
      4'd6:  r = ram;
      4'd7:  begin full = longint'(A) << amt; r = 16'(full); ov = ((full >> 16) != 0); lat = amt + 1; end
      4'd8:  begin r = 16'(A >> amt); lat = amt + 1; end
      4'd9:  r = 16'(A ^ B);
      4'd10: r = 16'hFFFF ^ 16'(A);
      4'd11: begin r = 16'(A - 1); ov = (A == 0); end
      4'd12: begin full = longint'(A) + 1; r = 16'(full); ov = (full > 65535); end
      4'd13: r = a;
      4'd14: r = inp;
      default: r = m[b][s];
    endcase
    if (o != 4'd0) m[b][d] = r;
    m_ovf = ov;
  endtask

  // Issue one op, then scramble the operand inputs and wait for done
  task automatic issue(input logic [3:0] o, input logic [1:0] d, input logic [1:0] s,
                       input logic [1:0] b, input logic [15:0] a, input logic [15:0] ram,
                       input logic [15:0] inp, input logic [15:0] md, output int lat);
    @(negedge clk);
    op = o; rd = d; rs = s; bank = b; arg = a; from_ram = ram; in_data = inp; muldiv = md;
    ext_we = 1'b0; op_valid = 1'b1;
    #1;
    chk("ready_before_accept", op_ready, 1);
    chk("read_req", read_req, (o == 4'd6));
    @(posedge clk); #1;
    op_valid = 1'b0;
    op = 4'($urandom); rd = 2'($urandom); rs = 2'($urandom); bank = 2'($urandom); arg = 16'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      chk("ready_while_busy", op_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; op_valid = 1'b0; ext_we = 1'b0;
    #1 chk("ready_in_reset", op_ready, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_reset", op_ready, 1);
    for (int b = 0; b < 4; b++) for (int s = 0; s < 4; s++) m[b][s] = '0;
    m_ovf = 1'b0;
  endtask

  initial begin
    int lat, elat, seen;
    logic [15:0] v, er;
    logic eo;
    rst = 1'b1; op_valid = 1'b0; op = '0; rd = '0; rs = '0; bank = '0; arg = '0;
    from_ram = '0; in_data = '0; muldiv = '0; ext_we = 1'b0; ext_data = '0;
    dbg_bank = '0; dbg_sel = '0;

    tv[0]  = mk(4'd13, 2'd0, 2'd0, 2'd0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'hFFFF, 1'b0, 1);
    tv[1]  = mk(4'd1,  2'd0, 2'd0, 2'd0, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0000, 1'b1, 1);
    tv[2]  = mk(4'd13, 2'd1, 2'd0, 2'd0, 16'h8001, 16'h0, 16'h0, 16'h0, 16'h8001, 1'b0, 1);
    tv[3]  = mk(4'd7,  2'd1, 2'd0, 2'd0, 16'h0003, 16'h0, 16'h0, 16'h0, 16'h0008, 1'b1, 4);
    tv[4]  = mk(4'd13, 2'd2, 2'd0, 2'd0, 16'h1234, 16'h0, 16'h0, 16'h0, 16'h1234, 1'b0, 1);
    tv[5]  = mk(4'd13, 2'd2, 2'd0, 2'd3, 16'hABCD, 16'h0, 16'h0, 16'h0, 16'hABCD, 1'b0, 1);
    tv[6]  = mk(4'd13, 2'd0, 2'd0, 2'd0, 16'h0005, 16'h0, 16'h0, 16'h0, 16'h0005, 1'b0, 1);
    tv[7]  = mk(4'd13, 2'd1, 2'd0, 2'd0, 16'h0007, 16'h0, 16'h0, 16'h0, 16'h0007, 1'b0, 1);
    tv[8]  = mk(4'd2,  2'd0, 2'd1, 2'd0, 16'h0000, 16'h0, 16'h0, 16'h0, 16'hFFFE, 1'b1, 1);
    tv[9]  = mk(4'd0,  2'd0, 2'd0, 2'd0, 16'h0000, 16'h0, 16'h0, 16'h0, 16'hFFFE, 1'b1, 1);
    tv[10] = mk(4'd6,  2'd3, 2'd0, 2'd1, 16'h0000, 16'h5A5A, 16'h0, 16'h0, 16'h5A5A, 1'b0, 1);
    tv[11] = mk(4'd14, 2'd0, 2'd0, 2'd1, 16'h0000, 16'h0, 16'h0F0F, 16'h0, 16'h0F0F, 1'b0, 1);
    tv[12] = mk(4'd5,  2'd1, 2'd0, 2'd1, 16'h0000, 16'h0, 16'h0, 16'hBEEF, 16'hBEEF, 1'b0, 1);
    tv[13] = mk(4'd15, 2'd2, 2'd1, 2'd1, 16'h7777, 16'h0, 16'h0, 16'h0, 16'hBEEF, 1'b0, 1);
    tv[14] = mk(4'd8,  2'd2, 2'd0, 2'd1, 16'h0010, 16'h0, 16'h0, 16'h0, 16'hBEEF, 1'b0, 1);
    tv[15] = mk(4'd7,  2'd2, 2'd0, 2'd1, 16'h0010, 16'h0, 16'h0, 16'h0, 16'hBEEF, 1'b0, 1);
    tv[16] = mk(4'd12, 2'd0, 2'd0, 2'd2, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0001, 1'b0, 1);
    tv[17] = mk(4'd11, 2'd1, 2'd0, 2'd2, 16'h0000, 16'h0, 16'h0, 16'h0, 16'hFFFF, 1'b1, 1);
    tv[18] = mk(4'd10, 2'd1, 2'd0, 2'd2, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0000, 1'b0, 1);
    tv[19] = mk(4'd13, 2'd2, 2'd0, 2'd2, 16'hF0F0, 16'h0, 16'h0, 16'h0, 16'hF0F0, 1'b0, 1);
    tv[20] = mk(4'd3,  2'd2, 2'd0, 2'd2, 16'h0FF0, 16'h0, 16'h0, 16'h0, 16'h00F0, 1'b0, 1);
    tv[21] = mk(4'd4,  2'd2, 2'd0, 2'd2, 16'h0F00, 16'h0, 16'h0, 16'h0, 16'h0FF0, 1'b0, 1);
    tv[22] = mk(4'd9,  2'd2, 2'd0, 2'd2, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'hF00F, 1'b0, 1);
    tv[23] = mk(4'd8,  2'd2, 2'd0, 2'd2, 16'h0004, 16'h0, 16'h0, 16'h0, 16'h0F00, 1'b0, 5);
    tv[24] = mk(4'd13, 2'd0, 2'd0, 2'd3, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'hFFFF, 1'b0, 1);
    tv[25] = mk(4'd12, 2'd0, 2'd0, 2'd3, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0000, 1'b1, 1);

    // Reset state
    do_reset();
    chk("reset_done", done, 0);
    chk("reset_overflow", overflow, 0);
    scan_all("reset_regs");

    // Directed table
    for (int i = 0; i < 26; i++) begin
      issue(tv[i].op, tv[i].rd, tv[i].rs, tv[i].bank, tv[i].arg, tv[i].ram, tv[i].inp, tv[i].md, lat);
      chk($sformatf("tv%0d_latency", i), lat, tv[i].lat);
      peek(tv[i].bank, tv[i].rd, v);
      chk($sformatf("tv%0d_result", i), v, tv[i].res);
      chk($sformatf("tv%0d_overflow", i), overflow, tv[i].ovf);
      if (tv[i].op != 4'd0) m[tv[i].bank][tv[i].rd] = tv[i].res;
      m_ovf = tv[i].ovf;
    end

    // Cross-bank peek
    peek(2'd0, 2'd2, v); chk("bank0_r2", v, 16'h1234);
    peek(2'd3, 2'd2, v); chk("bank3_r2", v, 16'hABCD);
    scan_all("after_table");

    // External write blocks an op offered in the same cycle
    @(negedge clk);
    op = 4'd13; rd = 2'd3; bank = 2'd2; arg = 16'h1111; op_valid = 1'b1;
    ext_we = 1'b1; ext_data = 16'h4321;
    #1 chk("ext_blocks_ready", op_ready, 0);
    @(posedge clk); #1;
    chk("ext_no_done", done, 0);
    ext_we = 1'b0; op_valid = 1'b0;
    peek(2'd2, 2'd3, v); chk("ext_written", v, 16'h4321);
    chk("ext_keeps_overflow", overflow, m_ovf);
    m[2][3] = 16'h4321;

    // External writes during a shift; the shift result wins on collision
    @(negedge clk);
    op = 4'd7; rd = 2'd3; rs = 2'd0; bank = 2'd2; arg = 16'h0002; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    ext_we = 1'b1; rd = 2'd2; ext_data = 16'h1111;
    @(posedge clk); #1;
    chk("collide_no_early_done", done, 0);
    rd = 2'd3; ext_data = 16'hDEAD;
    @(posedge clk); #1;
    ext_we = 1'b0;
    chk("collide_done", done, 1);
    peek(2'd2, 2'd3, v); chk("collide_shift_wins", v, 16'h0C84);
    peek(2'd2, 2'd2, v); chk("ext_during_shift", v, 16'h1111);
    chk("collide_overflow", overflow, 1);
    m[2][3] = 16'h0C84; m[2][2] = 16'h1111; m_ovf = 1'b1;

    // Random ops against the model
    for (int i = 0; i < 200; i++) begin
      logic [3:0] o; logic [1:0] d, s, b; logic [15:0] a, ram, inp, md;
      o = 4'($urandom); d = 2'($urandom); s = 2'($urandom); b = 2'($urandom);
      a = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0;
      ram = 16'($urandom); inp = 16'($urandom); md = 16'($urandom);
      model_op(o, d, s, b, a, ram, inp, md, er, eo, elat);
      issue(o, d, s, b, a, ram, inp, md, lat);
      chk($sformatf("rnd%0d_op%0d_latency", i, o), lat, elat);
      peek(b, d, v);
      chk($sformatf("rnd%0d_op%0d_result", i, o), v, er);
      chk($sformatf("rnd%0d_op%0d_overflow", i, o), overflow, eo);
      if (i % 20 == 19) scan_all("rnd_scan");
    end

    // Reset during the 4th SHIFT cycle of an 8-bit SHR aborts it
    issue(4'd13, 2'd3, 2'd0, 2'd0, 16'hFF00, 16'h0, 16'h0, 16'h0, lat);
    @(negedge clk);
    op = 4'd8; rd = 2'd3; bank = 2'd0; arg = 16'h0008; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1 chk("abort_ready_in_reset", op_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("abort_ready_after", op_ready, 1);
    chk("abort_overflow", overflow, 0);
    peek(2'd0, 2'd3, v); chk("abort_r3", v, 16'h0000);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", seen, 0);
    for (int b = 0; b < 4; b++) for (int s = 0; s < 4; s++) m[b][s] = '0;
    scan_all("abort_regs_clear");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_banked_seq.md
ALU_BANKED_SEQ -- requirements
Module: alu_banked_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath and register width (min 8).
REQ-002 SHALL have parameter NREGS, default 4, registers per bank (power of 2, min 2).
REQ-003 SHALL have parameter NBANKS, default 4, register banks (power of 2, min 1); RW = log2(NREGS), BW = max(1, log2(NBANKS)), SW = log2(WIDTH).
REQ-004 SHALL have port clk in 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst in 1, reset; synchronous, active-high.
REQ-006 SHALL have ports op_valid in 1 and op_ready out 1: operation handshake.
REQ-007 SHALL have port op in 4: opcode, encoded 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 RES, 6 READ, 7 SHL, 8 SHR, 9 XOR, 10 NOT, 11 DEC, 12 INC, 13 SET, 14 IN, 15 MOV.
REQ-008 SHALL have ports rd in RW, destination and first operand, and rs in RW, second operand register.
REQ-009 SHALL have ports bank in BW, active bank, and arg in WIDTH, immediate.
REQ-010 SHALL have ports from_ram, in_data and muldiv, each in WIDTH: sources for READ, IN and RES.
REQ-011 SHALL have ports ext_we in 1 and ext_data in WIDTH: external write to register rd of bank.
REQ-012 SHALL have ports dbg_bank in BW, dbg_sel in RW, dbg_data out WIDTH: combinational register peek.
REQ-013 SHALL have ports done out 1, one-cycle completion pulse; overflow out 1, registered flag; read_req out 1, RAM read strobe.

Function
REQ-014 Accept SHALL occur on a rising edge with op_valid=1 and op_ready=1; op, rd, rs, bank and arg SHALL be captured at accept.
REQ-015 op_ready SHALL be 1 only in state IDLE with ext_we=0.
REQ-016 opB SHALL be arg when arg != 0, else reg[bank][rs]; opA SHALL be reg[bank][rd].
REQ-017 ADD, SUB, AND, OR, XOR, NOT, DEC, INC, SET (arg), MOV (reg[rs], arg ignored), IN, RES, READ SHALL write reg[bank][rd] at the accept edge, with done=1 in the following cycle.
REQ-018 NOP SHALL write nothing, pulse done in the following cycle and leave overflow unchanged.
REQ-019 Arithmetic SHALL be unsigned modulo 2^WIDTH; overflow SHALL be the ADD/INC carry out of bit WIDTH-1, or the SUB/DEC borrow (opA < opB, opA == 0), else 0.
REQ-020 SHL/SHR: amount = opB[SW-1:0]; amount 0 SHALL complete as a single-cycle op, writing opA unchanged with overflow 0.
REQ-021 SHL/SHR with amount > 0 SHALL enter state SHIFT, shifting 1 bit per cycle, zero-fill, for exactly amount cycles, then write reg[bank][rd] at the final shift edge; done pulses the next cycle; latency = amount + 1 cycles from accept to done.
REQ-022 SHL overflow SHALL be 1 if any 1 bit was shifted out; SHR overflow SHALL be 0.
REQ-023 FSM SHALL have states IDLE and SHIFT; SHIFT returns to IDLE on the write edge; op_ready=0 throughout SHIFT.
REQ-024 Changes to bank, rd, rs or arg during SHIFT SHALL NOT affect the operation in flight.
REQ-025 ext_we=1 SHALL write ext_data to reg[bank][rd] at that edge, in any state, without pulsing done or touching overflow.
REQ-026 If ext_we and a SHIFT completion target the same register on the same edge, the shift result SHALL win.
REQ-027 read_req SHALL equal op_valid & op_ready & (op==READ), combinationally.
REQ-028 Banks SHALL be independent; a write SHALL change exactly one register.
REQ-029 dbg_data SHALL be reg[dbg_bank][dbg_sel], reflecting writes from the cycle after the write edge.

Reset
REQ-030 rst=1 SHALL clear all NBANKS*NREGS registers, overflow, done and the shift counter, and force IDLE.
REQ-031 rst SHALL abort an in-flight shift with no register write and no done pulse; rst SHALL have priority over ext_we and accept.
REQ-032 op_ready SHALL be 0 while rst=1 and SHALL be 1 in the first cycle after rst falls.

Verification
REQ-033 Reset, then SET r0=0xFFFF, then ADD r0, arg=1 -> r0=0x0000, overflow=1, done 1 cycle after each accept.
REQ-034 r1=0x8001, SHL r1, arg=3 -> op_ready=0 for 3 cycles, r1=0x0008, overflow=1, done 4 cycles after accept.
REQ-035 bank=0 SET r2=0x1234; bank=3 SET r2=0xABCD -> dbg_bank=0/dbg_sel=2 reads 0x1234; dbg_bank=3 reads 0xABCD.
REQ-036 Start SHR, arg=8, on r3=0xFF00; assert rst on the 4th SHIFT cycle -> no done pulse, r3=0, op_ready=1 the cycle after rst falls.
REQ-037 ext_we with op_valid=1 in IDLE -> op not accepted, ext_data written; SUB r0(5) minus rs r1(7), arg=0 -> r0=0xFFFE, overflow=1.
